// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide controller.
// The latency constants are cycles from the start cycle to the result_rdy cycle.
package multdiv_pkg;

    localparam int WIDTH    = 32;
    localparam int ITERS    = 32;
    localparam int CNT_W    = $clog2(ITERS);
    localparam int MULT_LAT = 33;
    localparam int DIV_LAT  = 36;
    localparam int DIVZ_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MULT   = 3'd1,
        ST_PREP_A = 3'd2,
        ST_PREP_B = 3'd3,
        ST_DIV    = 3'd4,
        ST_FIX    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Conditional one's complement; paired with cin=inv it yields a conditional negate.
    function automatic logic [WIDTH-1:0] cond_inv(input logic [WIDTH-1:0] v, input logic inv);
        return inv ? ~v : v;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_add32.sv
// Single 32-bit adder shared by every multiply and divide step.
// Subtraction is performed by the caller as a + ~b with cin=1.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit
// that time-shares one add32 instance across every arithmetic step.
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t state, state_next;
    logic [CNT_W-1:0] iter;

    // m_reg: multiplicand, or divisor magnitude. hi_reg: Booth high half, or
    // the divide remainder. lo_reg: multiplier/product low half, or quotient.
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             qm1_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] result_reg;
    logic             exception_reg;

    logic             start;
    logic             start_divz;
    logic             last_iter;
    logic [1:0]       booth;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_top;

    logic [WIDTH-1:0] mult_hi_next;
    logic [WIDTH-1:0] mult_lo_next;
    logic             div_accept;

    assign start      = ((state == ST_IDLE) || (state == ST_DONE)) && (ctrl_mult || ctrl_div);
    assign start_divz = !ctrl_mult && ctrl_div && (operand_b == '0);
    assign last_iter  = (iter == LAST_ITER);
    assign booth      = {lo_reg[0], qm1_reg};

    add32 u_add32 (
        .a    (add_x),
        .b    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand mux for the shared adder, selected by state and Booth bits.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state)
            ST_MULT: begin
                add_x = hi_reg;
                if (booth == 2'b01) begin
                    add_y = m_reg;
                end else if (booth == 2'b10) begin
                    add_y   = ~m_reg;
                    add_cin = 1'b1;
                end
            end
            ST_PREP_A: begin
                add_y   = cond_inv(lo_reg, lo_reg[WIDTH-1]);
                add_cin = lo_reg[WIDTH-1];
            end
            ST_PREP_B: begin
                add_y   = cond_inv(m_reg, m_reg[WIDTH-1]);
                add_cin = m_reg[WIDTH-1];
            end
            ST_DIV: begin
                add_x   = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
                add_y   = ~m_reg;
                add_cin = 1'b1;
            end
            ST_FIX: begin
                add_y   = cond_inv(lo_reg, neg_reg);
                add_cin = neg_reg;
            end
            default: ;
        endcase
    end

    // True 33rd sum bit of the sign-extended operands: shifting this in instead
    // of sum[31] keeps hi exact when +/-a overflows 32 bits (a = 0x80000000).
    assign add_top      = add_x[WIDTH-1] ^ add_y[WIDTH-1] ^ add_cout;
    assign mult_hi_next = {add_top, add_sum[WIDTH-1:1]};
    assign mult_lo_next = {add_sum[0], lo_reg[WIDTH-1:1]};

    // The shifted remainder's bit 32 is hi_reg[31]; if set, the trial always fits.
    assign div_accept   = add_cout | hi_reg[WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            iter  <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_MULT) || (state == ST_DIV)) begin
                iter <= iter + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (ctrl_mult)       state_next = ST_MULT;
                    else if (start_divz) state_next = ST_DONE;
                    else                 state_next = ST_PREP_A;
                end else if (state == ST_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MULT:   if (last_iter) state_next = ST_DONE;
            ST_PREP_A: state_next = ST_PREP_B;
            ST_PREP_B: state_next = ST_DIV;
            ST_DIV:    if (last_iter) state_next = ST_FIX;
            ST_FIX:    state_next = ST_DONE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = !((state == ST_IDLE) || (state == ST_DONE));
        result_rdy = (state == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            qm1_reg       <= 1'b0;
            neg_reg       <= 1'b0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
        end else if (start) begin
            m_reg         <= ctrl_mult ? operand_a : operand_b;
            lo_reg        <= ctrl_mult ? operand_b : operand_a;
            hi_reg        <= '0;
            qm1_reg       <= 1'b0;
            neg_reg       <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            result_reg    <= '0;
            exception_reg <= start_divz;
        end else begin
            case (state)
                ST_MULT: begin
                    hi_reg  <= mult_hi_next;
                    lo_reg  <= mult_lo_next;
                    qm1_reg <= lo_reg[0];
                    if (last_iter) begin
                        result_reg    <= mult_lo_next;
                        exception_reg <= (mult_hi_next != {WIDTH{mult_lo_next[WIDTH-1]}});
                    end
                end
                ST_PREP_A: lo_reg <= add_sum;
                ST_PREP_B: m_reg  <= add_sum;
                ST_DIV: begin
                    if (div_accept) begin
                        hi_reg <= add_sum;
                        lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_reg <= {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
                        lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
                    end
                end
                ST_FIX: begin
                    result_reg    <= add_sum;
                    // Only 0x80000000 / -1 yields a positive quotient with bit 31 set.
                    exception_reg <= !neg_reg && lo_reg[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    assign result    = result_reg;
    assign exception = exception_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: arithmetic reference model, per-cycle
// compare process, directed literal cases and randomized operations.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    multdiv_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int  checks = 0;
    int  errors = 0;
    bit  checking = 0;

    // Reference model state: current operation and what was visible before it.
    bit          m_active = 0;
    int unsigned m_t = 0;
    int unsigned m_done = 0;
    logic [31:0] m_res = 0;
    logic        m_exc = 0;
    bit          m_prev_valid = 0;
    int unsigned m_prev_done = 0;
    logic [31:0] m_prev_res = 0;
    logic        m_prev_exc = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic model_op(input bit do_mult, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic exc, output int lat);
        longint p;
        int     sa;
        int     sb;
        logic [31:0] low;
        if (do_mult) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            low = p[31:0];
            res = low;
            exc = (p != longint'($signed(low)));
            lat = MULT_LAT;
        end else if (b == 32'h0) begin
            res = 32'h0;
            exc = 1'b1;
            lat = DIVZ_LAT;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
            lat = DIV_LAT;
        end else begin
            sa  = $signed(a);
            sb  = $signed(b);
            res = sa / sb;
            exc = 1'b0;
            lat = DIV_LAT;
        end
    endtask

    // Called just after a rising edge; the pulse is sampled on the next edge.
    task automatic drive_start(input bit do_mult, input bit do_div,
                               input logic [31:0] a, input logic [31:0] b);
        int lat;
        m_prev_valid = m_active;
        m_prev_done  = m_done;
        m_prev_res   = m_active ? m_res : 32'h0;
        m_prev_exc   = m_active ? m_exc : 1'b0;
        model_op(do_mult, a, b, m_res, m_exc, lat);
        m_t      = cyc;
        m_done   = cyc + lat;
        m_active = 1;
        ctrl_mult = do_mult;
        ctrl_div  = do_div;
        operand_a = a;
        operand_b = b;
        $display("op %s a=%h b=%h start=%0d expect res=%h exc=%b at %0d",
                 do_mult ? "MUL" : "DIV", a, b, m_t, m_res, m_exc, m_done);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_rdy(input string name, input logic [31:0] lit_res,
                            input logic lit_exc, input int lat);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (result_rdy === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check1({name, "_rdy_seen"}, seen, 1'b1);
        if (seen) begin
            check32({name, "_latency"}, cyc - m_t, lat);
            check32({name, "_result"}, result, lit_res);
            check1({name, "_exception"}, exception, lit_exc);
        end
    endtask

    // Per-cycle compare against the model.
    logic [31:0] e_res;
    logic        e_exc, e_rdy, e_busy;
    always @(negedge clock) begin
        if (checking && !reset) begin
            if (!m_active) begin
                e_res = 0; e_exc = 0; e_rdy = 0; e_busy = 0;
            end else if (cyc <= m_t) begin
                e_res  = m_prev_res;
                e_exc  = m_prev_exc;
                e_rdy  = m_prev_valid && (cyc == m_prev_done);
                e_busy = 0;
            end else begin
                e_busy = (cyc < m_done);
                e_rdy  = (cyc == m_done);
                e_res  = (cyc >= m_done) ? m_res : 32'h0;
                e_exc  = (cyc >= m_done) ? m_exc : 1'b0;
            end
            check1("cyc_busy", busy, e_busy);
            check1("cyc_rdy", result_rdy, e_rdy);
            check32("cyc_result", result, e_res);
            check1("cyc_exception", exception, e_exc);
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ctrl_mult = 0; ctrl_div = 0; operand_a = 0; operand_b = 0;
        repeat (3) @(posedge clock);
        #1;
        check32("reset_result", result, 32'h0);
        check1("reset_exception", exception, 1'b0);
        check1("reset_rdy", result_rdy, 1'b0);
        check1("reset_busy", busy, 1'b0);
        reset = 1'b0;
        checking = 1;
        tick();

        drive_start(1, 0, 32'd7, 32'hFFFF_FFFD); tick();
        check1("mul_busy_t1", busy, 1'b1);
        wait_rdy("mul_7_m3", 32'hFFFF_FFEB, 1'b0, MULT_LAT);
        tick(); drive_start(1, 0, 32'h0001_0000, 32'h0001_0000); tick();
        wait_rdy("mul_ovf", 32'h0, 1'b1, MULT_LAT);
        tick(); drive_start(1, 0, 32'h8000_0000, 32'hFFFF_FFFF); tick();
        wait_rdy("mul_min_m1", 32'h8000_0000, 1'b1, MULT_LAT);

        tick(); drive_start(0, 1, 32'hFFFF_FFF9, 32'd2); tick();
        wait_rdy("div_m7_2", 32'hFFFF_FFFD, 1'b0, DIV_LAT);
        tick(); drive_start(0, 1, 32'd100, 32'hFFFF_FFF6); tick();
        wait_rdy("div_100_m10", 32'hFFFF_FFF6, 1'b0, DIV_LAT);
        tick(); drive_start(0, 1, 32'd5, 32'h0); tick();
        wait_rdy("div_by_zero", 32'h0, 1'b1, DIVZ_LAT);
        tick(); drive_start(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); tick();
        wait_rdy("div_min_m1", 32'h8000_0000, 1'b1, DIV_LAT);

        tick(); drive_start(1, 0, 32'd3, 32'd4); tick();
        repeat (9) tick();
        ctrl_div = 1'b1; operand_a = 32'd99; operand_b = 32'd0;
        tick();
        wait_rdy("mul_ignore_div", 32'd12, 1'b0, MULT_LAT);
        tick(); drive_start(1, 1, 32'd5, 32'd6); tick();
        wait_rdy("mul_div_both", 32'd30, 1'b0, MULT_LAT);

        tick(); drive_start(0, 1, 32'd1000, 32'd3); tick();
        repeat (12) tick();
        reset = 1'b1; m_active = 0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check32("abort_result", result, 32'h0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        drive_start(1, 0, 32'd6, 32'd7); tick();
        wait_rdy("mul_after_abort", 32'd42, 1'b0, MULT_LAT);
        tick();

        for (int n = 0; n < 60; n++) begin
            bit do_mult = 1'($urandom_range(0, 1));
            bit poke    = 1'($urandom_range(0, 1));
            int gap     = $urandom_range(0, 2);
            drive_start(do_mult, !do_mult, rand_operand(), rand_operand());
            tick();
            for (int w = 0; w < 60 && cyc < m_done; w++) begin
                if (poke && cyc == m_t + 5) begin
                    ctrl_mult = 1'b1; ctrl_div = 1'b1; operand_a = $urandom; operand_b = 0;
                end
                tick();
            end
            repeat (gap) tick();
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
